// File: rtl/vgaconsole_term_ctrl_if.sv
// Character stream, direct host write and text-buffer port bundle for the console write sequencer.
// The controller uses the slave modport; the surrounding system drives the master side.
interface vgaconsole_term_ctrl_if #(
    parameter int CHAR_W = 7
);
    logic              char_valid;
    logic [CHAR_W-1:0] char_data;
    logic              char_ready;

    logic              host_we;
    logic [4:0]        host_addr;
    logic [CHAR_W-1:0] host_wdata;

    logic [4:0]        buf_raddr;
    logic [CHAR_W-1:0] buf_rdata;
    logic              buf_we;
    logic [4:0]        buf_addr;
    logic [CHAR_W-1:0] buf_wdata;

    modport slave (
        input  char_valid, char_data, host_we, host_addr, host_wdata, buf_rdata,
        output char_ready, buf_raddr, buf_we, buf_addr, buf_wdata
    );

    modport master (
        output char_valid, char_data, host_we, host_addr, host_wdata, buf_rdata,
        input  char_ready, buf_raddr, buf_we, buf_addr, buf_wdata
    );
endinterface

// File: rtl/vgaconsole_term_ctrl.sv
// Terminal-style write sequencer for the VGA console text buffer: cursor tracking, control codes,
// wrap, scroll-up and clear, with direct host writes always winning the buffer write port.
//
// state       | meaning
// S_IDLE      | ready for the next stream character
// S_PUT       | writing the latched printable character at the cursor
// S_SCROLL_CP | copying rows 1..N-1 up by one row
// S_SCROLL_CL | blanking the last row, then cursor to start of last row
// S_CLEAR_ALL | blanking the whole buffer, then cursor home
module vgaconsole_term_ctrl #(
    parameter int NUM_ROWS = 3,
    parameter int NUM_COLS = 10,
    parameter int CHAR_W   = 7
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    vgaconsole_term_ctrl_if.slave       bus_if,
    output logic [1:0]                  cursor_row_o,
    output logic [3:0]                  cursor_col_o,
    output logic                        busy_o,
    output logic                        scroll_pulse_o
);
    localparam int NUM_CHARS = NUM_ROWS * NUM_COLS;
    localparam logic [4:0] LAST_IDX  = 5'(NUM_CHARS - 1);
    localparam logic [4:0] LAST_BASE = 5'((NUM_ROWS - 1) * NUM_COLS);
    localparam logic [4:0] COLS_A    = 5'(NUM_COLS);
    localparam logic [4:0] CHARS_A   = 5'(NUM_CHARS);
    localparam logic [1:0] LAST_ROW  = 2'(NUM_ROWS - 1);
    localparam logic [3:0] LAST_COL  = 4'(NUM_COLS - 1);

    localparam logic [CHAR_W-1:0] C_SPACE = CHAR_W'(32'h20);
    localparam logic [CHAR_W-1:0] C_TILDE = CHAR_W'(32'h7E);
    localparam logic [CHAR_W-1:0] C_LF    = CHAR_W'(32'h0A);
    localparam logic [CHAR_W-1:0] C_CR    = CHAR_W'(32'h0D);
    localparam logic [CHAR_W-1:0] C_BS    = CHAR_W'(32'h08);
    localparam logic [CHAR_W-1:0] C_FF    = CHAR_W'(32'h0C);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUT,
        S_SCROLL_CP,
        S_SCROLL_CL,
        S_CLEAR_ALL
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        row_q, row_d;
    logic [3:0]        col_q, col_d;
    logic [4:0]        idx_q, idx_d;
    logic [CHAR_W-1:0] code_q, code_d;
    logic              pulse_q, pulse_d;

    logic              ctl_we;
    logic [4:0]        ctl_addr;
    logic [CHAR_W-1:0] ctl_wdata;
    logic [4:0]        cur_addr;
    logic              stall;

    assign cur_addr = 5'(row_q) * COLS_A + 5'(col_q);
    assign stall    = bus_if.host_we;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            idx_q   <= '0;
            code_q  <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            idx_q   <= idx_d;
            code_q  <= code_d;
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        row_d            = row_q;
        col_d            = col_q;
        idx_d            = idx_q;
        code_d           = code_q;
        pulse_d          = 1'b0;
        ctl_we           = 1'b0;
        ctl_addr         = '0;
        ctl_wdata        = '0;
        bus_if.buf_raddr = '0;
        case (state_q)
            S_IDLE: begin
                if (bus_if.char_valid) begin
                    if (bus_if.char_data >= C_SPACE && bus_if.char_data <= C_TILDE) begin
                        code_d  = bus_if.char_data;
                        state_d = S_PUT;
                    end else if (bus_if.char_data == C_LF) begin
                        col_d = '0;
                        if (row_q == LAST_ROW) begin
                            idx_d   = COLS_A;
                            state_d = S_SCROLL_CP;
                        end else begin
                            row_d = row_q + 2'd1;
                        end
                    end else if (bus_if.char_data == C_CR) begin
                        col_d = '0;
                    end else if (bus_if.char_data == C_BS) begin
                        if (col_q != '0) col_d = col_q - 4'd1;
                    end else if (bus_if.char_data == C_FF) begin
                        idx_d   = '0;
                        state_d = S_CLEAR_ALL;
                    end
                end
            end
            S_PUT: begin
                ctl_we    = 1'b1;
                ctl_addr  = cur_addr;
                ctl_wdata = code_q;
                if (!stall) begin
                    state_d = S_IDLE;
                    if (col_q == LAST_COL) begin
                        col_d = '0;
                        if (row_q == LAST_ROW) begin
                            idx_d   = COLS_A;
                            state_d = S_SCROLL_CP;
                        end else begin
                            row_d = row_q + 2'd1;
                        end
                    end else begin
                        col_d = col_q + 4'd1;
                    end
                end
            end
            S_SCROLL_CP: begin
                // Read-modify-write in one cycle: the buffer read is combinational.
                bus_if.buf_raddr = idx_q;
                ctl_we           = 1'b1;
                ctl_addr         = idx_q - COLS_A;
                ctl_wdata        = bus_if.buf_rdata;
                if (!stall) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = LAST_BASE;
                        state_d = S_SCROLL_CL;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            S_SCROLL_CL: begin
                ctl_we    = 1'b1;
                ctl_addr  = idx_q;
                ctl_wdata = C_SPACE;
                if (!stall) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        row_d   = LAST_ROW;
                        col_d   = '0;
                        pulse_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            S_CLEAR_ALL: begin
                ctl_we    = 1'b1;
                ctl_addr  = idx_q;
                ctl_wdata = C_SPACE;
                if (!stall) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        row_d   = '0;
                        col_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus_if.buf_we    = ctl_we;
        bus_if.buf_addr  = ctl_addr;
        bus_if.buf_wdata = ctl_wdata;
        if (bus_if.host_we) begin
            bus_if.buf_we    = (bus_if.host_addr < CHARS_A);
            bus_if.buf_addr  = bus_if.host_addr;
            bus_if.buf_wdata = bus_if.host_wdata;
        end
    end

    assign bus_if.char_ready = (state_q == S_IDLE);
    assign busy_o            = (state_q == S_SCROLL_CP) || (state_q == S_SCROLL_CL) ||
                               (state_q == S_CLEAR_ALL);
    assign scroll_pulse_o    = pulse_q;
    assign cursor_row_o      = row_q;
    assign cursor_col_o      = col_q;
endmodule

// File: tb/tb_vgaconsole_term_ctrl.sv
// Directed bench for the console write sequencer: a table of stream characters with hand-computed
// buffer writes and cursors, then scroll, clear, host-priority and reset-abort sequences.
module tb_vgaconsole_term_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vgaconsole_term_ctrl_if #(.CHAR_W(7)) bus ();
    logic [1:0] cursor_row;
    logic [3:0] cursor_col;
    logic       busy;
    logic       scroll_pulse;

    vgaconsole_term_ctrl #(.NUM_ROWS(3), .NUM_COLS(10), .CHAR_W(7)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .bus_if         (bus),
        .cursor_row_o   (cursor_row),
        .cursor_col_o   (cursor_col),
        .busy_o         (busy),
        .scroll_pulse_o (scroll_pulse)
    );

    // Text buffer with combinational read, as seen by the controller.
    logic [6:0] mem [32];
    logic       mem_clr;
    assign bus.buf_rdata = mem[bus.buf_raddr];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else if (bus.buf_we) begin
            mem[bus.buf_addr] <= bus.buf_wdata;
        end
    end

    logic [6:0] exp_mem [32];
    logic [6:0] old_mem [32];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [6:0] code;
        logic       we;
        logic [4:0] addr;
        logic [1:0] row;
        logic [3:0] col;
    } vec_t;
    vec_t vecs [17];

    function automatic vec_t mk(input logic [6:0] c, input logic w, input logic [4:0] a,
                                input logic [1:0] r, input logic [3:0] cl);
        vec_t v;
        v.code = c; v.we = w; v.addr = a; v.row = r; v.col = cl;
        return v;
    endfunction

    task automatic send(input logic [6:0] code);
        int t;
        t = 0;
        while (!bus.char_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!bus.char_ready) chk("ready_timeout", 32'(bus.char_ready), 1);
        bus.char_valid = 1'b1;
        bus.char_data  = code;
        @(posedge clk); #1;
        bus.char_valid = 1'b0;
    endtask

    task automatic put_char(input string nm, input logic [6:0] code, input logic [4:0] addr);
        send(code);
        chk({nm, "_we"}, 32'(bus.buf_we), 1);
        chk({nm, "_addr"}, 32'(bus.buf_addr), 32'(addr));
        chk({nm, "_data"}, 32'(bus.buf_wdata), 32'(code));
        exp_mem[addr] = code;
        @(posedge clk); #1;
    endtask

    task automatic check_cursor(input string nm, input logic [1:0] r, input logic [3:0] c);
        chk({nm, "_row"}, 32'(cursor_row), 32'(r));
        chk({nm, "_col"}, 32'(cursor_col), 32'(c));
    endtask

    task automatic check_mem(input string nm);
        int bad;
        bad = 0;
        for (int i = 0; i < 32; i++) if (mem[i] !== exp_mem[i]) bad++;
        chk({nm, "_mem_bad_entries"}, 32'(bad), 0);
    endtask

    task automatic check_reset(input string nm);
        chk({nm, "_we"}, 32'(bus.buf_we), 0);
        chk({nm, "_addr"}, 32'(bus.buf_addr), 0);
        chk({nm, "_wdata"}, 32'(bus.buf_wdata), 0);
        chk({nm, "_raddr"}, 32'(bus.buf_raddr), 0);
        chk({nm, "_busy"}, 32'(busy), 0);
        chk({nm, "_pulse"}, 32'(scroll_pulse), 0);
        chk({nm, "_ready"}, 32'(bus.char_ready), 1);
        check_cursor(nm, 2'd0, 4'd0);
    endtask

    // Host-write schedule used while observing a multi-cycle sequence.
    int         hc [3];
    logic [4:0] ha [3];
    logic [6:0] hd [3];
    int         nhost;
    int         busy_cnt, nrdy_low, pulse_cnt, nw;
    logic [4:0] wa [64];
    logic [6:0] wd [64];

    task automatic run_window(input int ncyc);
        busy_cnt = 0; nrdy_low = 0; pulse_cnt = 0; nw = 0;
        for (int c = 0; c < ncyc; c++) begin
            int h;
            h = -1;
            for (int j = 0; j < nhost; j++) if (hc[j] == c) h = j;
            if (h >= 0) begin
                bus.host_we    = 1'b1;
                bus.host_addr  = ha[h];
                bus.host_wdata = hd[h];
            end else begin
                bus.host_we = 1'b0;
            end
            #1;
            if (h >= 0) begin
                chk("host_pass_we", 32'(bus.buf_we), 32'(ha[h] < 5'd30));
                chk("host_pass_addr", 32'(bus.buf_addr), 32'(ha[h]));
                chk("host_pass_data", 32'(bus.buf_wdata), 32'(hd[h]));
            end else if (bus.buf_we && nw < 64) begin
                wa[nw] = bus.buf_addr;
                wd[nw] = bus.buf_wdata;
                nw++;
            end
            if (busy) busy_cnt++;
            if (!bus.char_ready) nrdy_low++;
            if (scroll_pulse) pulse_cnt++;
            @(posedge clk); #1;
        end
        bus.host_we = 1'b0;
    endtask

    task automatic check_scroll(input string nm, input int exp_cycles);
        int bad;
        chk({nm, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_cycles));
        chk({nm, "_ready_low_cycles"}, 32'(nrdy_low), 32'(exp_cycles));
        chk({nm, "_writes"}, 32'(nw), 30);
        chk({nm, "_pulses"}, 32'(pulse_cnt), 1);
        bad = 0;
        for (int k = 0; k < nw; k++) begin
            if (wa[k] !== 5'(k)) bad++;
            else if (k < 20 && wd[k] !== old_mem[k + 10]) bad++;
            else if (k >= 20 && wd[k] !== 7'h20) bad++;
        end
        chk({nm, "_bad_writes"}, 32'(bad), 0);
        for (int k = 0; k < 20; k++) exp_mem[k] = old_mem[k + 10];
        for (int k = 20; k < 30; k++) exp_mem[k] = 7'h20;
        check_cursor(nm, 2'd2, 4'd0);
    endtask

    initial begin
        rst            = 1'b1;
        mem_clr        = 1'b1;
        bus.char_valid = 1'b0;
        bus.char_data  = '0;
        bus.host_we    = 1'b0;
        bus.host_addr  = '0;
        bus.host_wdata = '0;
        nhost          = 0;
        for (int i = 0; i < 32; i++) exp_mem[i] = '0;

        vecs[0]  = mk(7'h41, 1'b1, 5'd0,  2'd0, 4'd1);
        vecs[1]  = mk(7'h42, 1'b1, 5'd1,  2'd0, 4'd2);
        vecs[2]  = mk(7'h08, 1'b0, 5'd0,  2'd0, 4'd1);
        vecs[3]  = mk(7'h43, 1'b1, 5'd1,  2'd0, 4'd2);
        vecs[4]  = mk(7'h0D, 1'b0, 5'd0,  2'd0, 4'd0);
        vecs[5]  = mk(7'h08, 1'b0, 5'd0,  2'd0, 4'd0);
        vecs[6]  = mk(7'h0A, 1'b0, 5'd0,  2'd1, 4'd0);
        vecs[7]  = mk(7'h78, 1'b1, 5'd10, 2'd1, 4'd1);
        vecs[8]  = mk(7'h01, 1'b0, 5'd0,  2'd1, 4'd1);
        vecs[9]  = mk(7'h7F, 1'b0, 5'd0,  2'd1, 4'd1);
        vecs[10] = mk(7'h7E, 1'b1, 5'd11, 2'd1, 4'd2);
        vecs[11] = mk(7'h20, 1'b1, 5'd12, 2'd1, 4'd3);
        vecs[12] = mk(7'h61, 1'b1, 5'd13, 2'd1, 4'd4);
        vecs[13] = mk(7'h62, 1'b1, 5'd14, 2'd1, 4'd5);
        vecs[14] = mk(7'h0D, 1'b0, 5'd0,  2'd1, 4'd0);
        vecs[15] = mk(7'h08, 1'b0, 5'd0,  2'd1, 4'd0);
        vecs[16] = mk(7'h0A, 1'b0, 5'd0,  2'd2, 4'd0);

        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst     = 1'b0;
        mem_clr = 1'b0;

        // Table: printable, control and ignored codes from reset.
        for (int i = 0; i < 17; i++) begin
            send(vecs[i].code);
            chk($sformatf("vec%0d_we", i), 32'(bus.buf_we), 32'(vecs[i].we));
            if (vecs[i].we) begin
                chk($sformatf("vec%0d_addr", i), 32'(bus.buf_addr), 32'(vecs[i].addr));
                chk($sformatf("vec%0d_data", i), 32'(bus.buf_wdata), 32'(vecs[i].code));
                exp_mem[vecs[i].addr] = vecs[i].code;
            end
            @(posedge clk); #1;
            check_cursor($sformatf("vec%0d", i), vecs[i].row, vecs[i].col);
            chk($sformatf("vec%0d_ready", i), 32'(bus.char_ready), 1);
        end
        check_mem("table");

        // Fill the last row; the tenth character wraps into a scroll.
        for (int i = 0; i < 10; i++) put_char($sformatf("row2_c%0d", i), 7'(8'h30 + i), 5'(20 + i));
        old_mem = exp_mem;
        nhost = 0;
        run_window(40);
        check_scroll("scroll1", 30);
        check_mem("scroll1");

        // Same scroll with three host writes that must stall the sequence.
        for (int i = 0; i < 10; i++) put_char($sformatf("row2b_c%0d", i), 7'(8'h61 + i), 5'(20 + i));
        old_mem = exp_mem;
        nhost = 3;
        hc[0] = 5;  ha[0] = 5'd1; hd[0] = 7'h51;
        hc[1] = 12; ha[1] = 5'd2; hd[1] = 7'h55;
        hc[2] = 20; ha[2] = 5'd5; hd[2] = 7'h66;
        run_window(40);
        nhost = 0;
        check_scroll("scroll_host", 33);
        exp_mem[1] = 7'h51;
        exp_mem[2] = 7'h55;
        exp_mem[5] = 7'h66;
        check_mem("scroll_host");

        // Form feed from a non-home cursor.
        put_char("pre_ff", 7'h5A, 5'd20);
        send(7'h0C);
        run_window(40);
        chk("ff_busy_cycles", 32'(busy_cnt), 30);
        chk("ff_writes", 32'(nw), 30);
        chk("ff_pulses", 32'(pulse_cnt), 0);
        begin
            int bad;
            bad = 0;
            for (int k = 0; k < nw; k++) if (wa[k] !== 5'(k) || wd[k] !== 7'h20) bad++;
            chk("ff_bad_writes", 32'(bad), 0);
        end
        for (int k = 0; k < 30; k++) exp_mem[k] = 7'h20;
        check_cursor("ff", 2'd0, 4'd0);
        check_mem("ff");

        // Host write lands during PUT; PUT holds and completes afterwards.
        send(7'h51);
        bus.host_we    = 1'b1;
        bus.host_addr  = 5'd7;
        bus.host_wdata = 7'h12;
        #1;
        chk("put_stall_addr", 32'(bus.buf_addr), 7);
        chk("put_stall_data", 32'(bus.buf_wdata), 32'h12);
        exp_mem[7] = 7'h12;
        @(posedge clk); #1;
        bus.host_we = 1'b0;
        #1;
        chk("put_resume_we", 32'(bus.buf_we), 1);
        chk("put_resume_addr", 32'(bus.buf_addr), 0);
        chk("put_resume_data", 32'(bus.buf_wdata), 32'h51);
        exp_mem[0] = 7'h51;
        @(posedge clk); #1;
        check_cursor("put_stall", 2'd0, 4'd1);

        // Wrap from the end of a non-last row.
        for (int i = 1; i < 10; i++) put_char($sformatf("row0_c%0d", i), 7'(8'h51 + i), 5'(i));
        check_cursor("wrap_row0", 2'd1, 4'd0);

        // Out-of-range host address is suppressed but still owns the port.
        bus.host_we    = 1'b1;
        bus.host_addr  = 5'd30;
        bus.host_wdata = 7'h11;
        #1;
        chk("host_oob_we", 32'(bus.buf_we), 0);
        @(posedge clk); #1;
        bus.host_we = 1'b0;
        check_cursor("host_oob", 2'd1, 4'd0);
        check_mem("host_oob");

        // LF on the last row starts a scroll; reset aborts it part way.
        send(7'h0A);
        check_cursor("lf_row2", 2'd2, 4'd0);
        send(7'h0A);
        chk("lf_scroll_busy", 32'(busy), 1);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset("abort");
        @(posedge clk); #1;
        rst = 1'b0;
        put_char("post_reset", 7'h4B, 5'd0);
        check_cursor("post_reset", 2'd0, 4'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach its end");
        $fatal(1);
    end
endmodule
